// File: rtl/rf_spill_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_spill_fill_ctrl_if
// Purpose  : Register-file and memory handshake bundle for the spill/fill
//            controller.
// Revision : 1.0
// ============================================================================
interface rf_spill_fill_ctrl_if #(
    parameter int NBITS = 64,
    parameter int AW    = 16
);
    logic             SPILL;
    logic             FILL;
    logic [NBITS-1:0] RF_DOUT;
    logic             RF_DOUT_READY;
    logic [NBITS-1:0] RF_DIN;
    logic             RF_DIN_VALID;
    logic             MEM_REQ;
    logic             MEM_WE;
    logic [AW-1:0]    MEM_ADDR;
    logic [NBITS-1:0] MEM_WDATA;
    logic             MEM_ACK;
    logic [NBITS-1:0] MEM_RDATA;
    logic             STALL;
    logic [AW-1:0]    SP;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    // Controller side
    modport master (
        input  SPILL, FILL, RF_DOUT, MEM_ACK, MEM_RDATA,
        output RF_DOUT_READY, RF_DIN, RF_DIN_VALID, MEM_REQ, MEM_WE,
               MEM_ADDR, MEM_WDATA, STALL, SP, OVERFLOW, UNDERFLOW
    );

    // Register file / memory side
    modport slave (
        output SPILL, FILL, RF_DOUT, MEM_ACK, MEM_RDATA,
        input  RF_DOUT_READY, RF_DIN, RF_DIN_VALID, MEM_REQ, MEM_WE,
               MEM_ADDR, MEM_WDATA, STALL, SP, OVERFLOW, UNDERFLOW
    );
endinterface
`default_nettype wire

// File: rtl/rf_spill_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_spill_fill_ctrl
// Purpose  : Moves 2*N-word register windows between the register file and
//            a memory-resident spill stack.
// Revision : 1.0
// ============================================================================
module rf_spill_fill_ctrl #(
    parameter int NBITS       = 64,
    parameter int N           = 3,
    parameter int AW          = 16,
    parameter int STACK_DEPTH = 12
) (
    input  logic                    CLK,
    input  logic                    RESET,
    rf_spill_fill_ctrl_if.master    bus
);

    localparam int W  = 2 * N;
    localparam int KW = (W > 1) ? $clog2(W) : 1;

    localparam logic [AW:0]   W_EXT     = (AW + 1)'(W);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(STACK_DEPTH);
    localparam logic [AW-1:0] W_AW      = AW'(W);
    localparam logic [KW-1:0] K_LAST    = KW'(W - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SPILL_XFER = 2'd1,
        FILL_XFER  = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [KW-1:0]    k;
    logic [AW-1:0]    sp;
    logic [NBITS-1:0] rf_din;
    logic             rf_din_valid;
    logic             overflow;
    logic             underflow;

    logic             spill_ok;
    logic             fill_ok;
    logic             last_word;
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic             rf_dout_ready;

    // Compare one bit wider than SP so SP+W cannot wrap.
    assign spill_ok  = ({1'b0, sp} + W_EXT) <= DEPTH_EXT;
    assign fill_ok   = {1'b0, sp} >= W_EXT;
    assign last_word = (k == K_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus outputs are decoded from state, so reset clears them at once.
    always_comb begin
        state_nxt     = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rf_dout_ready = 1'b0;
        case (state)
            IDLE: begin
                if (bus.SPILL) begin
                    if (spill_ok) begin
                        state_nxt = SPILL_XFER;
                    end
                end else if (bus.FILL && fill_ok) begin
                    state_nxt = FILL_XFER;
                end
            end
            SPILL_XFER: begin
                mem_req       = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = sp + AW'(k);
                mem_wdata     = bus.RF_DOUT;
                rf_dout_ready = bus.MEM_ACK;
                if (bus.MEM_ACK && last_word) begin
                    state_nxt = DONE;
                end
            end
            FILL_XFER: begin
                mem_req  = 1'b1;
                mem_addr = sp - W_AW + AW'(k);
                if (bus.MEM_ACK && last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            k            <= '0;
            sp           <= '0;
            rf_din       <= '0;
            rf_din_valid <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rf_din_valid <= 1'b0;
            case (state)
                IDLE: begin
                    k <= '0;
                    // SPILL has priority; a concurrent FILL is dropped.
                    if (bus.SPILL) begin
                        if (!spill_ok) begin
                            overflow <= 1'b1;
                        end
                    end else if (bus.FILL && !fill_ok) begin
                        underflow <= 1'b1;
                    end
                end
                SPILL_XFER: begin
                    if (bus.MEM_ACK) begin
                        k <= k + KW'(1);
                        if (last_word) begin
                            sp <= sp + W_AW;
                        end
                    end
                end
                FILL_XFER: begin
                    if (bus.MEM_ACK) begin
                        rf_din       <= bus.MEM_RDATA;
                        rf_din_valid <= 1'b1;
                        k            <= k + KW'(1);
                        if (last_word) begin
                            sp <= sp - W_AW;
                        end
                    end
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

    assign bus.MEM_REQ       = mem_req;
    assign bus.MEM_WE        = mem_we;
    assign bus.MEM_ADDR      = mem_addr;
    assign bus.MEM_WDATA     = mem_wdata;
    assign bus.RF_DOUT_READY = rf_dout_ready;
    assign bus.RF_DIN        = rf_din;
    assign bus.RF_DIN_VALID  = rf_din_valid;
    assign bus.STALL         = (state != IDLE);
    assign bus.SP            = sp;
    assign bus.OVERFLOW      = overflow;
    assign bus.UNDERFLOW     = underflow;

endmodule
`default_nettype wire

// File: doc/rf_spill_fill_ctrl.md
RF_SPILL_FILL_CTRL -- requirements
Module: rf_spill_fill_ctrl

Interface
- REQ-001: Parameters, one per line: name, default, meaning.
  - NBITS, 64, register/data word width.
  - N, 3, registers per window block; one transfer moves W = 2*N words.
  - AW, 16, memory address width.
  - STACK_DEPTH, 12, spill-stack capacity in words, counted from address 0.
- REQ-002: Ports, one per line: name, direction, width, meaning.
  - CLK, in, 1, single clock; all state changes on the rising edge.
  - RESET, in, 1, asynchronous, active-high reset.
  - SPILL, in, 1, spill request from the register file.
  - FILL, in, 1, fill request from the register file.
  - RF_DOUT, in, NBITS, current spill word presented by the register file.
  - RF_DOUT_READY, out, 1, pulse: register file advances to its next spill word.
  - RF_DIN, out, NBITS, fill word to the register file.
  - RF_DIN_VALID, out, 1, pulse: RF_DIN is valid this cycle.
  - MEM_REQ, out, 1, memory request.
  - MEM_WE, out, 1, 1 = write (spill), 0 = read (fill).
  - MEM_ADDR, out, AW, word address.
  - MEM_WDATA, out, NBITS, write data.
  - MEM_ACK, in, 1, memory acknowledge.
  - MEM_RDATA, in, NBITS, read data, valid when MEM_ACK = 1.
  - STALL, out, 1, pipeline hold while a transfer is in progress.
  - SP, out, AW, spill-stack pointer (next free word).
  - OVERFLOW, out, 1, sticky error flag.
  - UNDERFLOW, out, 1, sticky error flag.

Function
- REQ-003: The FSM SHALL have four states: IDLE, SPILL_XFER, FILL_XFER and DONE. STALL SHALL equal (state != IDLE), decoded directly from the state register.
- REQ-004: In IDLE, SPILL sampled high with SP+W <= STACK_DEPTH SHALL move the FSM to SPILL_XFER, and clear the word counter k.
- REQ-005: In IDLE, FILL sampled high with SP >= W SHALL move the FSM to FILL_XFER, and clear the word counter k.
- REQ-006: In SPILL_XFER, the outputs SHALL be MEM_REQ=1, MEM_WE=1, MEM_ADDR=SP+k and MEM_WDATA=RF_DOUT.
  - In the cycle MEM_ACK=1, RF_DOUT_READY SHALL pulse for 1 cycle and k SHALL increment.
- REQ-007: In FILL_XFER, the outputs SHALL be MEM_REQ=1, MEM_WE=0 and MEM_ADDR=SP-W+k.
  - In the cycle MEM_ACK=1, MEM_RDATA SHALL be registered into RF_DIN.
  - RF_DIN_VALID SHALL pulse in the following cycle.
  - k SHALL increment.
- REQ-008: Handshake rules:
  - MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA SHALL hold stable until MEM_ACK is sampled high.
  - Same-cycle ack SHALL be accepted, giving 1 word per cycle at best.
  - Any number of wait cycles SHALL be tolerated.
- REQ-009: On the ack of word k=W-1:
  - SP SHALL update: +W for a spill, -W for a fill.
  - The FSM SHALL enter DONE.
  - MEM_REQ SHALL drop to 0 in DONE.
- REQ-010: DONE SHALL last exactly 1 cycle and then return to IDLE. A transfer with no wait states therefore holds STALL for W+1 cycles.
- REQ-011: SPILL and FILL both high in IDLE: SPILL SHALL win and FILL SHALL be dropped silently.
- REQ-012: SPILL or FILL asserted outside IDLE SHALL be ignored.
- REQ-013: SPILL with SP+W > STACK_DEPTH SHALL:
  - set OVERFLOW,
  - issue no MEM_REQ,
  - leave SP unchanged,
  - keep the FSM in IDLE.
- REQ-014: FILL with SP < W SHALL set UNDERFLOW and behave otherwise the same as REQ-013.
- REQ-015: OVERFLOW and UNDERFLOW SHALL be sticky; only RESET clears them.
- REQ-016: MEM_REQ, RF_DOUT_READY and RF_DIN_VALID SHALL never be high in IDLE.

Reset
- REQ-017: RESET=1 SHALL immediately, without waiting for a clock edge, force:
  - state to IDLE;
  - SP, k and RF_DIN to 0;
  - MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, RF_DOUT_READY, RF_DIN_VALID, STALL, OVERFLOW and UNDERFLOW to 0.
- REQ-018: Reset during a transfer SHALL abandon it with no SP update. The first request after reset release SHALL be evaluated normally.

Verification
- REQ-019: The bench SHALL use N=3 (W=6), STACK_DEPTH=12 and AW=16, and SHALL cover these scenarios:
  - Reset pulse mid-idle -> all outputs 0, SP=0.
  - SPILL pulse, MEM_ACK tied 1, RF_DOUT = 0xA0+k -> writes to addresses 0..5 with data 0xA0..0xA5, 6 RF_DOUT_READY pulses, STALL high 7 cycles, SP=6.
  - Then FILL, MEM_RDATA = 0xA0+address, ACK tied 1 -> reads addresses 0..5, RF_DIN_VALID pulses carrying 0xA0..0xA5 in order, SP=0.
  - SPILL with ACK held low for 3 cycles on word 2 -> MEM_ADDR=2 and MEM_WDATA stable across the wait, no extra RF_DOUT_READY, SP=6 at end.
  - Two spills (SP=12), then a third SPILL -> OVERFLOW=1, no MEM_REQ, SP=12. After reset, FILL at SP=0 -> UNDERFLOW=1.
  - SPILL and FILL high together at SP=0 -> spill only, SP=6. Then RESET asserted after the word-2 ack of a second spill -> MEM_REQ=0 asynchronously, SP=0, STALL=0.
